// File: rtl/keypad_scan.sv
// keypad_scan: time-multiplexed reader for a 4x4 active-low key matrix.
//
// One column strobe is driven low at a time. Each column dwells 2**SCAN_BITS clk
// cycles. The synchronized rows are sampled at the end of each dwell. Four dwells
// make one frame. Frame summaries (any key / first key / more than one key) feed a
// debounce FSM. The FSM accepts a press or a release only after DB_SCANS
// consecutive identical frames.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high
//   row_n[3:0]   in   matrix rows, active-low, asynchronous to clk
//   col_n[3:0]   out  column strobes, active-low, exactly one low
//   key_code[3:0]out  last accepted key, col*4 + row
//   key_valid    out  one-cycle pulse when a press is accepted
//   key_release  out  one-cycle pulse when a release is accepted
//   key_held     out  high from key_valid until key_release
module keypad_scan #(
  parameter int SCAN_BITS = 16,
  parameter int DB_SCANS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_held
);

  localparam int CW = $clog2(DB_SCANS + 1);
  // Count value at which the next qualifying frame completes debouncing.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_SCANS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  logic [3:0]           row_meta_r;
  logic [3:0]           row_sync_r;
  logic [SCAN_BITS-1:0] presc_r;
  logic [1:0]           col_idx_r;
  logic                 acc_pressed_r;
  logic                 acc_multi_r;
  logic [3:0]           acc_code_r;
  state_t               state_r;
  logic [3:0]           cand_r;
  logic [CW-1:0]        cnt_r;

  logic                 tick_s;
  logic                 frame_end_s;
  logic                 frame_pressed_s;
  logic                 frame_multi_s;
  logic [3:0]           frame_code_s;
  logic                 good_s;

  assign tick_s      = (presc_r == {SCAN_BITS{1'b1}});
  assign frame_end_s = tick_s && (col_idx_r == 2'd3);
  assign good_s      = frame_pressed_s && !frame_multi_s;

  // Frame summary including the current column's rows, so that the frame-end
  // tick evaluates all four columns. Rows are scanned low index first, which
  // keeps the earliest key in scan order as the frame code.
  always_comb begin
    frame_pressed_s = acc_pressed_r;
    frame_multi_s   = acc_multi_r;
    frame_code_s    = acc_code_r;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_r[r]) begin
        if (frame_pressed_s) begin
          frame_multi_s = 1'b1;
        end else begin
          frame_pressed_s = 1'b1;
          frame_code_s    = {col_idx_r, 2'(r)};
        end
      end else begin
        frame_multi_s = frame_multi_s;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_r <= 4'b1111;
      row_sync_r <= 4'b1111;
    end else begin
      row_meta_r <= row_n;
      row_sync_r <= row_meta_r;
    end
  end

  // Prescaler, column strobe sequencing and per-frame accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r       <= '0;
      col_idx_r     <= 2'd0;
      col_n         <= 4'b1110;
      acc_pressed_r <= 1'b0;
      acc_multi_r   <= 1'b0;
      acc_code_r    <= 4'd0;
    end else begin
      presc_r <= presc_r + SCAN_BITS'(1);
      if (tick_s) begin
        col_idx_r <= col_idx_r + 2'd1;
        col_n     <= ~(4'b0001 << (col_idx_r + 2'd1));
        if (frame_end_s) begin
          acc_pressed_r <= 1'b0;
          acc_multi_r   <= 1'b0;
          acc_code_r    <= 4'd0;
        end else begin
          acc_pressed_r <= frame_pressed_s;
          acc_multi_r   <= frame_multi_s;
          acc_code_r    <= frame_code_s;
        end
      end
    end
  end

  // Debounce FSM, evaluated once per frame, with registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cand_r      <= 4'd0;
      cnt_r       <= '0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (frame_end_s) begin
        case (state_r)
          IDLE: begin
            if (good_s) begin
              cand_r <= frame_code_s;
              if (DB_SCANS == 1) begin
                state_r   <= HELD;
                cnt_r     <= '0;
                key_code  <= frame_code_s;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                state_r <= PRESS_DB;
                cnt_r   <= CW'(1);
              end
            end else begin
              cnt_r <= '0;
            end
          end
          PRESS_DB: begin
            if (good_s && (frame_code_s == cand_r)) begin
              if (cnt_r >= CNT_LAST) begin
                state_r   <= HELD;
                cnt_r     <= '0;
                key_code  <= cand_r;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CW'(1);
              end
            end else begin
              // A changed, multiple or missing key aborts; the next frame
              // starts a fresh candidate from IDLE.
              state_r <= IDLE;
              cnt_r   <= '0;
            end
          end
          HELD: begin
            // Any pressed frame, even a different or multiple key, keeps
            // the current key held: there is no rollover.
            if (!frame_pressed_s) begin
              if (DB_SCANS == 1) begin
                state_r     <= IDLE;
                cnt_r       <= '0;
                key_release <= 1'b1;
                key_held    <= 1'b0;
              end else begin
                state_r <= REL_DB;
                cnt_r   <= CW'(1);
              end
            end else begin
              cnt_r <= '0;
            end
          end
          REL_DB: begin
            if (!frame_pressed_s) begin
              if (cnt_r >= CNT_LAST) begin
                state_r     <= IDLE;
                cnt_r       <= '0;
                key_release <= 1'b1;
                key_held    <= 1'b0;
              end else begin
                cnt_r <= cnt_r + CW'(1);
              end
            end else begin
              // Release bounce: silently back to HELD, key_code untouched.
              state_r <= HELD;
              cnt_r   <= '0;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end
        endcase
      end
    end
  end

endmodule
